// File: rtl/lives_display_ctrl_pkg.sv
// Shared game types: life-flow states, icon geometry and the 11-bit screen coordinate.
// The coordinate type is shared with the bitmap modules.
package lives_display_ctrl_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    OVER   = 2'd2
  } life_state_t;

  localparam int ICON_SIZE = 72;
  localparam int COORD_W   = 11;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/lives_icon_scan.sv
// Maps the scan pixel onto the icon row: parallel slot compare against constant
// slot starts, offset subtract, then one output register stage.
module lives_icon_scan
  import lives_display_ctrl_pkg::*;
#(
  parameter int MAX_LIVES = 5,
  parameter int ORIGIN_X  = 16,
  parameter int ORIGIN_Y  = 8,
  parameter int ICON_SIZE = lives_display_ctrl_pkg::ICON_SIZE,
  parameter int ICON_GAP  = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  coord_t     pixelX,
  input  coord_t     pixelY,
  input  logic [2:0] vis_lives,
  input  logic       hidden,
  output logic       InsideRectangle,
  output coord_t     offsetX,
  output coord_t     offsetY
);

  localparam int PITCH = ICON_SIZE + ICON_GAP;

  coord_t rel_x;
  coord_t rel_y;
  coord_t off_x;
  logic   in_row;
  logic   in_slot;
  logic   inside_c;

  always_comb begin
    rel_x   = pixelX - coord_t'(ORIGIN_X);
    rel_y   = pixelY - coord_t'(ORIGIN_Y);
    // Left of / above the origin wraps to a huge unsigned value, so reject it explicitly.
    in_row  = (pixelX >= coord_t'(ORIGIN_X)) && (pixelY >= coord_t'(ORIGIN_Y)) &&
              (rel_y < coord_t'(ICON_SIZE));
    in_slot = 1'b0;
    off_x   = '0;
    for (int k = 0; k < MAX_LIVES; k++) begin
      if ((3'(k) < vis_lives) && (rel_x >= coord_t'(k * PITCH)) &&
          (rel_x < coord_t'(k * PITCH + ICON_SIZE))) begin
        in_slot = 1'b1;
        off_x   = rel_x - coord_t'(k * PITCH);
      end
    end
    inside_c = in_row && in_slot && !hidden;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      InsideRectangle <= 1'b0;
      offsetX         <= '0;
      offsetY         <= '0;
    end else begin
      InsideRectangle <= inside_c;
      offsetX         <= inside_c ? off_x : '0;
      offsetY         <= inside_c ? rel_y : '0;
    end
  end

endmodule

// File: rtl/lives_display_ctrl.sv
// Life counter and hit/invulnerability/game-over FSM; visibility is latched per frame
// and handed to the icon scanner that time-shares one bitmap across the row.
module lives_display_ctrl
  import lives_display_ctrl_pkg::*;
#(
  parameter int MAX_LIVES     = 5,
  parameter int INIT_LIVES    = 3,
  parameter int ORIGIN_X      = 16,
  parameter int ORIGIN_Y      = 8,
  parameter int ICON_SIZE     = lives_display_ctrl_pkg::ICON_SIZE,
  parameter int ICON_GAP      = 8,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  coord_t     pixelX,
  input  coord_t     pixelY,
  input  logic       hit,
  input  logic       extraLife,
  input  logic       newGame,
  output logic       InsideRectangle,
  output coord_t     offsetX,
  output coord_t     offsetY,
  output logic [2:0] lives,
  output logic       invulnerable,
  output logic       gameOver
);

  localparam int BLINK_BIT = $clog2(BLINK_FRAMES);
  localparam int CNT_W     = ($clog2(INVULN_FRAMES) > BLINK_BIT) ? $clog2(INVULN_FRAMES)
                                                                 : BLINK_BIT + 1;
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(INVULN_FRAMES - 1);

  life_state_t      state, state_nxt;
  logic [2:0]       lives_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       vis_lives;
  logic             hidden, hidden_nxt;

  always_comb begin
    state_nxt = state;
    lives_nxt = lives;
    cnt_nxt   = cnt;
    if (newGame) begin
      state_nxt = ALIVE;
      lives_nxt = 3'(INIT_LIVES);
      cnt_nxt   = '0;
    end else begin
      case (state)
        ALIVE: begin
          if (hit) begin
            cnt_nxt = '0;
            if (lives > 3'd1) begin
              lives_nxt = lives - 3'd1;
              state_nxt = INVULN;
            end else begin
              lives_nxt = 3'd0;
              state_nxt = OVER;
            end
          end else if (extraLife && (lives < 3'(MAX_LIVES))) begin
            lives_nxt = lives + 3'd1;
          end
        end
        INVULN: begin
          // A same-cycle hit still outranks extraLife, even though the hit itself is ignored.
          if (!hit && extraLife && (lives < 3'(MAX_LIVES))) lives_nxt = lives + 3'd1;
          if (startOfFrame) begin
            if (cnt == LAST_FRAME) begin
              state_nxt = ALIVE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        OVER: lives_nxt = 3'd0;
        default: state_nxt = ALIVE;
      endcase
    end
    hidden_nxt = (state_nxt == INVULN) && cnt_nxt[BLINK_BIT];
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= ALIVE;
      lives     <= 3'(INIT_LIVES);
      cnt       <= '0;
      vis_lives <= 3'(INIT_LIVES);
      hidden    <= 1'b0;
    end else begin
      state <= state_nxt;
      lives <= lives_nxt;
      cnt   <= cnt_nxt;
      // Icons only change on frame boundaries so nothing tears mid-frame.
      if (startOfFrame) begin
        vis_lives <= lives_nxt;
        hidden    <= hidden_nxt;
      end
    end
  end

  assign invulnerable = (state == INVULN);
  assign gameOver     = (state == OVER);

  lives_icon_scan #(
    .MAX_LIVES (MAX_LIVES),
    .ORIGIN_X  (ORIGIN_X),
    .ORIGIN_Y  (ORIGIN_Y),
    .ICON_SIZE (ICON_SIZE),
    .ICON_GAP  (ICON_GAP)
  ) u_scan (
    .clk             (clk),
    .resetN          (resetN),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .vis_lives       (vis_lives),
    .hidden          (hidden),
    .InsideRectangle (InsideRectangle),
    .offsetX         (offsetX),
    .offsetY         (offsetY)
  );

endmodule

// File: tb/tb_lives_display_ctrl.sv
// Directed bench for lives_display_ctrl: expected scan and life-state results are
// queued when stimulus is applied and compared once the DUT registers them.
module tb_lives_display_ctrl;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX, pixelY;
  logic        hit, extraLife, newGame;
  logic        InsideRectangle;
  logic [10:0] offsetX, offsetY;
  logic [2:0]  lives;
  logic        invulnerable, gameOver;

  typedef struct packed {
    logic        ins;
    logic [10:0] ox;
    logic [10:0] oy;
  } scan_exp_t;

  typedef struct packed {
    logic [2:0] lv;
    logic       inv;
    logic       go;
  } life_exp_t;

  scan_exp_t scan_q[$];
  life_exp_t life_q[$];
  int checks = 0;
  int errors = 0;

  lives_display_ctrl dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .hit             (hit),
    .extraLife       (extraLife),
    .newGame         (newGame),
    .InsideRectangle (InsideRectangle),
    .offsetX         (offsetX),
    .offsetY         (offsetY),
    .lives           (lives),
    .invulnerable    (invulnerable),
    .gameOver        (gameOver)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_life(input string tag);
    life_exp_t e, o;
    e = life_q.pop_front();
    o = '{lv: lives, inv: invulnerable, go: gameOver};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed lives=%0d inv=%0b over=%0b expected lives=%0d inv=%0b over=%0b",
             tag, o.lv, o.inv, o.go, e.lv, e.inv, e.go);
    end
  endtask

  // Apply one cycle of event pulses, then compare the life state it produces.
  task automatic events(input string tag, input logic h, input logic x, input logic n,
                        input int lv, input logic inv, input logic go);
    hit = h; extraLife = x; newGame = n;
    life_q.push_back('{lv: 3'(lv), inv: inv, go: go});
    tick();
    hit = 1'b0; extraLife = 1'b0; newGame = 1'b0;
    pop_life(tag);
  endtask

  task automatic expect_life(input string tag, input int lv, input logic inv, input logic go);
    life_q.push_back('{lv: 3'(lv), inv: inv, go: go});
    pop_life(tag);
  endtask

  task automatic scan(input string tag, input int x, input int y,
                      input logic ins, input int ox, input int oy);
    scan_exp_t e, o;
    pixelX = 11'(x);
    pixelY = 11'(y);
    scan_q.push_back('{ins: ins, ox: 11'(ox), oy: 11'(oy)});
    tick();
    e = scan_q.pop_front();
    o = '{ins: InsideRectangle, ox: offsetX, oy: offsetY};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed inside=%0b off=(%0d,%0d) expected inside=%0b off=(%0d,%0d)",
             tag, o.ins, o.ox, o.oy, e.ins, e.ox, e.oy);
    end
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; hit = 1'b0; extraLife = 1'b0; newGame = 1'b0;
    pixelX = '0; pixelY = '0;
    tick();
    // Reset overrides an on-icon pixel.
    scan("reset_scan", 16, 8, 1'b0, 0, 0);
    expect_life("reset_state", 3, 1'b0, 1'b0);
    resetN = 1'b1;

    scan("origin", 16, 8, 1'b1, 0, 0);
    scan("slot3_absent", 16 + 3*80, 8, 1'b0, 0, 0);
    scan("slot1_off", 16 + 80 + 5, 8 + 10, 1'b1, 5, 10);
    scan("gap", 16 + 75, 8, 1'b0, 0, 0);
    scan("left_of_origin", 15, 8, 1'b0, 0, 0);
    scan("above_origin", 16, 7, 1'b0, 0, 0);
    scan("icon0_corner", 16 + 71, 8 + 71, 1'b1, 71, 71);
    scan("icon0_right_edge", 16 + 72, 8, 1'b0, 0, 0);
    scan("below_row", 16, 8 + 72, 1'b0, 0, 0);
    scan("slot2_last", 16 + 160 + 71, 8 + 3, 1'b1, 71, 3);

    events("hit_3", 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    repeat (9) tick();
    events("hit_ignored", 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0);

    for (int n = 1; n <= 120; n++) begin
      sof();
      if (n <= 23)
        scan("blink_icon0", 16 + 3, 8 + 3, (n >= 8 && n <= 15) ? 1'b0 : 1'b1,
             (n >= 8 && n <= 15) ? 0 : 3, (n >= 8 && n <= 15) ? 0 : 3);
      if (n == 12) scan("blink_icon1", 16 + 80, 8, 1'b0, 0, 0);
      if (n == 20) scan("visible_icon1", 16 + 80, 8, 1'b1, 0, 0);
      if (n == 20) scan("slot2_after_hit", 16 + 160, 8, 1'b0, 0, 0);
      if (n == 119) expect_life("invuln_119", 2, 1'b1, 1'b0);
    end
    expect_life("invuln_done", 2, 1'b0, 1'b0);

    events("hit_and_extra", 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0);
    repeat (120) sof();
    expect_life("invuln_done2", 1, 1'b0, 1'b0);
    events("last_hit", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    sof();
    scan("over_no_icons", 16, 8, 1'b0, 0, 0);
    events("over_extra", 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    events("over_hit", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    events("new_game", 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    scan("no_midframe_change", 16, 8, 1'b0, 0, 0);
    sof();
    scan("new_game_slot2", 16 + 160, 8, 1'b1, 0, 0);

    events("extra_to4", 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0);
    events("extra_to5", 1'b0, 1'b1, 1'b0, 5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) events("extra_sat", 1'b0, 1'b1, 1'b0, 5, 1'b0, 1'b0);
    sof();
    scan("slot4_off", 16 + 320 + 3, 8 + 4, 1'b1, 3, 4);

    events("hit_5", 1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0);
    events("extra_invuln", 1'b0, 1'b1, 1'b0, 5, 1'b1, 1'b0);
    events("newgame_priority", 1'b1, 1'b1, 1'b1, 3, 1'b0, 1'b0);
    events("hit_again", 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    resetN = 1'b0;
    tick();
    expect_life("reset_mid_invuln", 3, 1'b0, 1'b0);
    resetN = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lives_display_ctrl.md
# lives_display_ctrl

Life-count controller and icon-row scheduler for the player's lives display. It holds the current life count and sequences the hit/invulnerability/game-over flow from game events. It scans the VGA pixel stream and drives the lives-icon bitmap with a rectangle-qualify signal and per-icon offsets, so one 36x36 bitmap (drawn 2x, 72x72 on screen) is time-shared across up to MAX_LIVES on-screen icons. It sits between the game-logic event sources and the lives bitmap / object mux.

## Interface
- MAX_LIVES, 5: saturation limit of the life counter, 1..7
- INIT_LIVES, 3: lives after reset or newGame, 1..MAX_LIVES
- ORIGIN_X, 16 / ORIGIN_Y, 8: top-left pixel of the icon row
- ICON_SIZE, 72: on-screen icon edge in pixels (bitmap scaled 2x)
- ICON_GAP, 8: horizontal pixels between icons
- INVULN_FRAMES, 120: frames of invulnerability after a hit
- BLINK_FRAMES, 8: frames per blink half-period while invulnerable
- clk  in  1  system pixel clock
- resetN  in  1  reset; one clock, reset is synchronous and active-low
- startOfFrame  in  1  one-cycle pulse per video frame
- pixelX, pixelY  in  11 each  current scan pixel
- hit  in  1  one-cycle pulse: player struck
- extraLife  in  1  one-cycle pulse: award a life
- newGame  in  1  one-cycle pulse: restart
- InsideRectangle  out  1  pixel falls inside a visible icon
- offsetX, offsetY  out  11 each  pixel offset within the current icon, 0..ICON_SIZE-1
- lives  out  3  current life count
- invulnerable  out  1  high in state INVULN
- gameOver  out  1  high in state OVER

## Operation
- FSM states: ALIVE, INVULN, OVER. Reset → ALIVE, lives=INIT_LIVES, frame counter 0, all outputs 0 except lives.
- Event priority, highest first: newGame, hit, extraLife. Same-cycle lower-priority events are discarded.
- newGame, any state → ALIVE, lives=INIT_LIVES, counters cleared.
- ALIVE + hit: lives>1 → lives−1, go to INVULN, frame counter=0. lives==1 → lives=0, go to OVER.
- INVULN: hit is ignored. The frame counter increments on each startOfFrame. When the counter reaches INVULN_FRAMES−1 and startOfFrame is high → ALIVE.
- extraLife in ALIVE or INVULN: lives+1, saturating at MAX_LIVES. Ignored in OVER.
- OVER: only newGame leaves the state. lives=0.
- Icon scan: relX=pixelX−ORIGIN_X and relY=pixelY−ORIGIN_Y. Both are unsigned; a pixel left of or above the origin is outside.
  - Slot k (0..lives−1) covers relX in [k·P, k·P+ICON_SIZE−1], where P=ICON_SIZE+ICON_GAP. The row covers relY in [0, ICON_SIZE−1].
  - The slot is found by a parallel compare against the constant slot starts. There is no divider.
  - Gap pixels and slots ≥ lives are outside.
- Blink: in INVULN, icons are hidden while bit log2(BLINK_FRAMES) of the frame counter is 1. A hidden icon forces InsideRectangle=0.
- Inside a visible icon: offsetX=relX−k·P and offsetY=relY. Outside: offsets are 0 and InsideRectangle=0.

## Timing
- Events are sampled on posedge clk. lives, state, invulnerable and gameOver update on the edge after the pulse, giving 1-cycle latency.
- Scan outputs are registered and lag pixelX/pixelY by exactly 1 cycle. The bitmap adds 1 more, for a total of 2 cycles.
- Blink and visibility changes take effect only on the edge where startOfFrame is sampled, so the icons do not tear mid-frame.
- Reset asserted mid-INVULN: on the next edge, state=ALIVE and lives=INIT_LIVES.
- The counter is wide enough for INVULN_FRAMES−1 and never wraps in INVULN.

## Structure
- Shared game package: the state enum type (ALIVE/INVULN/OVER), the ICON_SIZE constant, and the 11-bit coordinate typedef, which is also used by the bitmap modules.
- One sub-module, lives_icon_scan: a combinational slot compare and offset subtract, followed by the output register. The FSM, the life counter and the frame counter stay in the top.

## Test plan
- Reset, then scan pixel (16,8) → 1 cycle later InsideRectangle=1, offset (0,0). Scan (16+3·80,8) with lives=3 → InsideRectangle=0.
- Scan pixel (16+80+5, 8+10) → slot 1, offset (5,10). Scan (16+75,8), a gap pixel → InsideRectangle=0.
- Pulse hit with lives=3 → lives=2 and invulnerable=1. A second hit 10 cycles later → ignored. After 120 startOfFrame pulses → ALIVE.
- In INVULN, check frames 8..15 → InsideRectangle=0 on every icon pixel. Frames 16..23 → icons visible again.
- With lives=1: hit → lives=0, gameOver=1, scan shows no icons. extraLife → ignored. newGame → lives=3, ALIVE.
- hit and extraLife in the same cycle with lives=2 → lives=1. extraLife ×4 from lives=4 → lives=5, saturated.
